// File: rtl/agdc_pkg.sv
// Shared package for the garage door controller and its door plant.
// Holds the state encoding so that controller and plant waveforms decode
// identically, plus a small helper used by both sides.
package agdc_pkg;

  // Encoding is fixed explicitly so waveform viewers and checkers can rely on it.
  typedef enum logic [1:0] {
    STOPPED  = 2'd0,
    RAISING  = 2'd1,
    LOWERING = 2'd2,
    FAULT    = 2'd3
  } agdc_state_e;

  localparam logic [1:0] ST_STOPPED  = 2'd0;
  localparam logic [1:0] ST_RAISING  = 2'd1;
  localparam logic [1:0] ST_LOWERING = 2'd2;
  localparam logic [1:0] ST_FAULT    = 2'd3;

  function automatic logic is_moving(input agdc_state_e st);
    return (st == RAISING) || (st == LOWERING);
  endfunction

endpackage

// File: rtl/gdp_step_timer.sv
// Step timer for the door plant.
// Counts CLK edges while enabled and flags the edge on which one position
// step is due (cnt == TICK_DIV-1); the counter wraps to 0 on that edge.
// Ports:
//   CLK    in  clock, rising edge
//   RST    in  asynchronous active-low reset (cnt <= 0)
//   clear  in  synchronous clear, has priority over enable
//   enable in  count this edge; neither clear nor enable holds cnt
//   step   out high while cnt == TICK_DIV-1 (caller qualifies with enable)
module gdp_step_timer #(
  parameter int TICK_DIV = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic enable,
  output logic step
);
  import agdc_pkg::*;

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign step = (cnt == CNT_LAST);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= step ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/garage_door_plant.sv
// Door mechanism model on the motor side of the garage door controller.
// Consumes motor commands UP_M/DN_M and produces limit switches from an
// internal position counter. Closed-loop partner for system benches and
// FPGA demo boards.
// Optional feature macro: GDP_OBSTRUCT_EN adds Obstruct/Obst_Hit; while an
// object is in the path, lowering pauses with its step phase preserved.
// Ports:
//   CLK, RST       clock (rising edge), asynchronous active-low reset
//   UP_M, DN_M     motor raise / lower commands
//   UP_Max, DN_Max registered limit switches (Pos==TRAVEL_STEPS / Pos==0)
//   Pos            current door position
//   Moving         1 while RAISING or LOWERING
//   Fault          sticky, both commands seen high together; only RST clears
//   Obstruct       [GDP_OBSTRUCT_EN] object in door path
//   Obst_Hit       [GDP_OBSTRUCT_EN] lowering blocked this cycle (registered)
//   Dbg_State      current FSM state for waveform decoding and checkers
// Handshake: none; commands are levels sampled on every rising CLK edge.
module garage_door_plant #(
  parameter int TRAVEL_STEPS = 100,
  parameter int TICK_DIV     = 4,
  localparam int POS_W       = $clog2(TRAVEL_STEPS + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  UP_M,
  input  logic                  DN_M,
  output logic                  UP_Max,
  output logic                  DN_Max,
  output logic [POS_W-1:0]      Pos,
  output logic                  Moving,
  output logic                  Fault,
`ifdef GDP_OBSTRUCT_EN
  input  logic                  Obstruct,
  output logic                  Obst_Hit,
`endif
  output agdc_pkg::agdc_state_e Dbg_State
);
  import agdc_pkg::*;

  localparam logic [POS_W-1:0] POS_MAX = POS_W'(TRAVEL_STEPS);

  agdc_state_e      state, state_d;
  logic [POS_W-1:0] pos_d;
  logic             tmr_clear, tmr_enable, tmr_step;
  logic             blocked, obst_d;

`ifdef GDP_OBSTRUCT_EN
  assign blocked = Obstruct;
`else
  assign blocked = 1'b0;
`endif

  gdp_step_timer #(.TICK_DIV(TICK_DIV)) u_step_timer (
    .CLK    (CLK),
    .RST    (RST),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .step   (tmr_step)
  );

  always_comb begin
    state_d    = state;
    pos_d      = Pos;
    tmr_clear  = 1'b1;
    tmr_enable = 1'b0;
    obst_d     = 1'b0;
    if (UP_M && DN_M) begin
      state_d = FAULT;
    end else begin
      unique case (state)
        STOPPED: begin
          // A command toward a limit already reached is ignored.
          if (UP_M && (Pos < POS_MAX))   state_d = RAISING;
          else if (DN_M && (Pos != '0))  state_d = LOWERING;
        end
        RAISING: begin
          if (UP_M) begin
            tmr_clear  = 1'b0;
            tmr_enable = 1'b1;
            if (tmr_step) begin
              pos_d = Pos + 1'b1;
              if (pos_d == POS_MAX) state_d = STOPPED;
            end
          end else if (DN_M && (Pos != '0)) begin
            state_d = LOWERING;
          end else begin
            state_d = STOPPED;
          end
        end
        LOWERING: begin
          if (DN_M) begin
            tmr_clear = 1'b0;
            if (blocked) begin
              // Hold the step phase so lowering resumes where it paused.
              obst_d = 1'b1;
            end else begin
              tmr_enable = 1'b1;
              if (tmr_step) begin
                pos_d = Pos - 1'b1;
                if (pos_d == '0) state_d = STOPPED;
              end
            end
          end else if (UP_M && (Pos < POS_MAX)) begin
            state_d = RAISING;
          end else begin
            state_d = STOPPED;
          end
        end
        FAULT: state_d = FAULT;
        default: state_d = FAULT;
      endcase
    end
  end

  // Limits and flags are registered from next-state values so they move on
  // the same edge as Pos and state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= STOPPED;
      Pos    <= '0;
      UP_Max <= 1'b0;
      DN_Max <= 1'b1;
      Moving <= 1'b0;
      Fault  <= 1'b0;
    end else begin
      state  <= state_d;
      Pos    <= pos_d;
      UP_Max <= (pos_d == POS_MAX);
      DN_Max <= (pos_d == '0);
      Moving <= is_moving(state_d);
      Fault  <= (state_d == FAULT);
    end
  end

`ifdef GDP_OBSTRUCT_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) Obst_Hit <= 1'b0;
    else      Obst_Hit <= obst_d;
  end
`endif

  assign Dbg_State = state;

endmodule

// File: tb/tb_garage_door_plant.sv
// Self-checking bench for garage_door_plant (TRAVEL_STEPS=4, TICK_DIV=2).
// A behavioural door model updated on every rising edge is compared with
// the DUT one time unit later; directed scenarios add literal expectations.
module tb_garage_door_plant;
  import agdc_pkg::*;

  localparam int TRAVEL = 4;
  localparam int TICK   = 2;
  localparam int POS_W  = $clog2(TRAVEL + 1);

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic UP_M = 1'b0;
  logic DN_M = 1'b0;
  logic UP_Max, DN_Max, Moving, Fault;
  logic [POS_W-1:0] Pos;
  agdc_state_e Dbg_State;
`ifdef GDP_OBSTRUCT_EN
  logic Obstruct = 1'b0;
  logic Obst_Hit;
`endif

  always #5 CLK = ~CLK;

  garage_door_plant #(.TRAVEL_STEPS(TRAVEL), .TICK_DIV(TICK)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .UP_M      (UP_M),
    .DN_M      (DN_M),
    .UP_Max    (UP_Max),
    .DN_Max    (DN_Max),
    .Pos       (Pos),
    .Moving    (Moving),
    .Fault     (Fault),
`ifdef GDP_OBSTRUCT_EN
    .Obstruct  (Obstruct),
    .Obst_Hit  (Obst_Hit),
`endif
    .Dbg_State (Dbg_State)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 going up, 2 going down, 3 jammed (fault)
  int m_pos = 0;
  int m_mode = 0;
  int m_held = 0;   // edges the current motion has been held since entry/last step
  bit m_obst = 1'b0;

  function automatic agdc_state_e mode_name(input int mode);
    case (mode)
      1: return RAISING;
      2: return LOWERING;
      3: return FAULT;
      default: return STOPPED;
    endcase
  endfunction

  task automatic model_reset();
    m_pos = 0; m_mode = 0; m_held = 0; m_obst = 1'b0;
  endtask

  task automatic model_edge(input bit up, input bit dn, input bit ob);
    int dir;
    m_obst = 1'b0;
    if (up && dn) begin
      m_mode = 3;
      return;
    end
    if (m_mode == 3) return;
    if (m_mode == 0) begin
      m_held = 0;
      if (up && m_pos < TRAVEL) m_mode = 1;
      else if (dn && m_pos > 0) m_mode = 2;
      return;
    end
    // Moving: keep going only while the matching command is held.
    if ((m_mode == 1 && up) || (m_mode == 2 && dn)) begin
      if (m_mode == 2 && ob) begin
        m_obst = 1'b1;
        return;
      end
      dir = (m_mode == 1) ? 1 : -1;
      m_held = m_held + 1;
      if (m_held % TICK == 0) begin
        m_held = 0;
        m_pos = m_pos + dir;
        if (m_pos == 0 || m_pos == TRAVEL) m_mode = 0;
      end
    end else begin
      m_held = 0;
      if (m_mode == 1 && dn && m_pos > 0)          m_mode = 2;
      else if (m_mode == 2 && up && m_pos < TRAVEL) m_mode = 1;
      else                                          m_mode = 0;
    end
  endtask

  // Compare process: model advances on each edge, DUT sampled 1 unit later.
  always @(posedge CLK) begin
    bit up, dn, ob;
    up = UP_M;
    dn = DN_M;
    ob = 1'b0;
`ifdef GDP_OBSTRUCT_EN
    ob = Obstruct;
`endif
    if (!RST) model_reset();
    else      model_edge(up, dn, ob);
    #1;
    if (checking) begin
      check("pos",    int'(Pos),       m_pos);
      check("up_max", int'(UP_Max),    (m_pos == TRAVEL) ? 1 : 0);
      check("dn_max", int'(DN_Max),    (m_pos == 0) ? 1 : 0);
      check("moving", int'(Moving),    (m_mode == 1 || m_mode == 2) ? 1 : 0);
      check("fault",  int'(Fault),     (m_mode == 3) ? 1 : 0);
      check("state",  int'(Dbg_State), int'(mode_name(m_mode)));
`ifdef GDP_OBSTRUCT_EN
      check("obst_hit", int'(Obst_Hit), int'(m_obst));
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit up, input bit dn, input bit ob);
    @(negedge CLK);
    UP_M = up;
    DN_M = dn;
`ifdef GDP_OBSTRUCT_EN
    Obstruct = ob;
`else
    if (ob) begin end
`endif
    @(posedge CLK);
    #2;
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    RST  = 1'b0;
    UP_M = 1'b0;
    DN_M = 1'b0;
`ifdef GDP_OBSTRUCT_EN
    Obstruct = 1'b0;
`endif
    @(negedge CLK);
    RST = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit up, dn, ob;
    int r;
    checking = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b1;

    // Reset release, idle
    drive(0, 0, 0);
    check("lit_rst_pos", int'(Pos), 0);
    check("lit_rst_dnmax", int'(DN_Max), 1);
    check("lit_rst_upmax", int'(UP_Max), 0);
    check("lit_rst_moving", int'(Moving), 0);
    check("lit_rst_fault", int'(Fault), 0);

    // Full open: entry edge + 8 edges
    for (int i = 0; i < 9; i++) begin
      drive(1, 0, 0);
      if (i == 0) check("lit_open_moving0", int'(Moving), 1);
      if (i == 2) begin
        check("lit_open_pos1", int'(Pos), 1);
        check("lit_open_dnmax", int'(DN_Max), 0);
      end
    end
    check("lit_open_pos4", int'(Pos), 4);
    check("lit_open_upmax", int'(UP_Max), 1);
    check("lit_open_moving", int'(Moving), 0);

    // Overtravel ignored
    drive(1, 0, 0);
    check("lit_overtravel", int'(Moving), 0);

    // Full close
    repeat (9) drive(0, 1, 0);
    check("lit_close_pos", int'(Pos), 0);
    check("lit_close_dnmax", int'(DN_Max), 1);

    // Raise to Pos=2 with a half-done step, then drop the command
    repeat (6) drive(1, 0, 0);
    drive(0, 0, 0);
    check("lit_drop_pos", int'(Pos), 2);
    check("lit_drop_upmax", int'(UP_Max), 0);
    check("lit_drop_dnmax", int'(DN_Max), 0);
    check("lit_drop_moving", int'(Moving), 0);
    drive(1, 0, 0);
    drive(1, 0, 0);
    check("lit_resume_hold", int'(Pos), 2);
    drive(1, 0, 0);
    check("lit_resume_step", int'(Pos), 3);

    // Reversal at Pos=3
    drive(0, 1, 0);
    check("lit_rev_state", int'(Dbg_State), int'(LOWERING));
    check("lit_rev_pos", int'(Pos), 3);
    repeat (2) drive(0, 1, 0);
    check("lit_rev_pos2", int'(Pos), 2);
    repeat (4) drive(0, 1, 0);
    check("lit_rev_pos0", int'(Pos), 0);
    check("lit_rev_dnmax", int'(DN_Max), 1);

    // Obstruction while lowering from the top
    repeat (9) drive(1, 0, 0);
    drive(0, 1, 0);
    drive(0, 1, 0);
    repeat (5) drive(0, 1, 1);
`ifdef GDP_OBSTRUCT_EN
    check("lit_obst_pos", int'(Pos), 4);
    check("lit_obst_hit", int'(Obst_Hit), 1);
    drive(0, 1, 0);
    check("lit_obst_resume", int'(Pos), 3);
    check("lit_obst_clear", int'(Obst_Hit), 0);
`else
    check("lit_obst_pos", int'(Pos), 1);
`endif
    repeat (12) drive(0, 1, 0);

    // Fault mid-travel
    repeat (3) drive(1, 0, 0);
    drive(1, 1, 0);
    check("lit_fault_set", int'(Fault), 1);
    check("lit_fault_moving", int'(Moving), 0);
    check("lit_fault_pos", int'(Pos), 1);
    repeat (3) drive(0, 0, 0);
    drive(1, 0, 0);
    check("lit_fault_sticky", int'(Fault), 1);
    check("lit_fault_frozen", int'(Pos), 1);
    pulse_reset();
    check("lit_fault_rst", int'(Fault), 0);
    check("lit_fault_rst_pos", int'(Pos), 0);

    // Random run: mostly held commands, occasional changes, rare jams/resets
    up = 1'b0; dn = 1'b0; ob = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2 || (m_mode == 3 && r < 15)) begin
        pulse_reset();
        up = 1'b0; dn = 1'b0;
      end else begin
        if (r < 20) begin
          r = int'($urandom_range(0, 19));
          up = (r < 8);
          dn = (r >= 8 && r < 16);
          if (r == 19) begin up = 1'b1; dn = 1'b1; end
        end
        ob = ($urandom_range(0, 4) == 0);
        drive(up, dn, ob);
      end
    end

    checking = 1'b0;
    @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
